// File: rtl/complete_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : complete_arbiter
// Description : Per-pipe 2-entry completion FIFOs drained round-robin onto a
//               registered single-completion-per-cycle broadcast bus.
// Revision    : 1.0 - initial release
// ============================================================================
module complete_arbiter #(
    parameter int p_num_pipes      = 2,
    parameter int p_num_phys_regs  = 36,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = $clog2(p_num_phys_regs)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [p_phys_addr_bits-1:0] pipe_preg    [p_num_pipes],
    input  logic [4:0]                  pipe_areg    [p_num_pipes],
    input  logic [p_seq_num_bits-1:0]   pipe_seq_num [p_num_pipes],
    input  logic [31:0]                 pipe_wdata   [p_num_pipes],
    input  logic                        pipe_wen     [p_num_pipes],
    input  logic                        pipe_en      [p_num_pipes],
    output logic                        pipe_rdy     [p_num_pipes],
    output logic                        complete_val,
    output logic [p_phys_addr_bits-1:0] complete_preg,
    output logic [4:0]                  complete_areg,
    output logic [p_seq_num_bits-1:0]   complete_seq_num,
    output logic [31:0]                 complete_wdata,
    output logic                        complete_wen
);

    localparam int c_ptr_bits   = $clog2(p_num_pipes);
    localparam int c_entry_bits = p_phys_addr_bits + 5 + p_seq_num_bits + 32 + 1;

    logic [1:0]              fifo_count [p_num_pipes];
    logic [c_entry_bits-1:0] fifo_head  [p_num_pipes];
    logic [c_ptr_bits-1:0]   ptr;
    logic [c_ptr_bits-1:0]   grant_idx;
    logic                    grant_val;

    generate
        for (genvar i = 0; i < p_num_pipes; i++) begin : g_fifo
            logic [c_entry_bits-1:0] mem [2];
            logic                    rd_ptr;
            logic                    wr_ptr;
            logic [1:0]              count;
            logic                    push;
            logic                    pop;

            // A write into a full FIFO is dropped rather than corrupting the head.
            assign push = pipe_en[i] && (count != 2'd2);
            assign pop  = grant_val && (grant_idx == c_ptr_bits'(i));

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr] <= {pipe_preg[i], pipe_areg[i], pipe_seq_num[i],
                                    pipe_wdata[i], pipe_wen[i]};
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    count  <= 2'd0;
                    rd_ptr <= 1'b0;
                    wr_ptr <= 1'b0;
                end else begin
                    if (push) wr_ptr <= ~wr_ptr;
                    if (pop)  rd_ptr <= ~rd_ptr;
                    count <= count + {1'b0, push} - {1'b0, pop};
                end
            end

            assign fifo_count[i] = count;
            assign fifo_head[i]  = mem[rd_ptr];
            assign pipe_rdy[i]   = (count != 2'd2);
        end
    endgenerate

    // Scan pipes starting at ptr; the first non-empty one wins.
    always_comb begin
        int                    idx;
        logic [c_ptr_bits-1:0] idx_b;
        grant_val = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_b     = '0;
        for (int k = 0; k < p_num_pipes; k++) begin
            idx   = (int'(ptr) + k) % p_num_pipes;
            idx_b = c_ptr_bits'(idx);
            if (!grant_val && (fifo_count[idx_b] != 2'd0)) begin
                grant_val = 1'b1;
                grant_idx = idx_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_val) begin
            ptr <= (grant_idx == c_ptr_bits'(p_num_pipes - 1)) ? '0
                                                                : grant_idx + c_ptr_bits'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            complete_val     <= 1'b0;
            complete_preg    <= '0;
            complete_areg    <= '0;
            complete_seq_num <= '0;
            complete_wdata   <= '0;
            complete_wen     <= 1'b0;
        end else begin
            complete_val <= grant_val;
            if (grant_val) begin
                {complete_preg, complete_areg, complete_seq_num,
                 complete_wdata, complete_wen} <= fifo_head[grant_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complete_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_complete_arbiter
// Description : Scoreboard bench for complete_arbiter (2-pipe and 3-pipe builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_complete_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int vectors     = 0;
    int miscompares = 0;
    int valid_seen  = 0;

    typedef struct {
        logic [5:0]  preg;
        logic [4:0]  areg;
        logic [4:0]  seq;
        logic [31:0] wdata;
        logic        wen;
        int          at;
    } exp_t;

    exp_t qa[$];
    exp_t qw[$];
    exp_t ea;
    exp_t ew;

    logic [5:0]  a_preg  [2];
    logic [4:0]  a_areg  [2];
    logic [4:0]  a_seq   [2];
    logic [31:0] a_wdata [2];
    logic        a_wen   [2];
    logic        a_en    [2];
    logic        a_rdy   [2];
    logic        a_val;
    logic [5:0]  a_cpreg;
    logic [4:0]  a_careg;
    logic [4:0]  a_cseq;
    logic [31:0] a_cwdata;
    logic        a_cwen;

    logic [5:0]  w_preg  [3];
    logic [4:0]  w_areg  [3];
    logic [4:0]  w_seq   [3];
    logic [31:0] w_wdata [3];
    logic        w_wen   [3];
    logic        w_en    [3];
    logic        w_rdy   [3];
    logic        w_val;
    logic [5:0]  w_cpreg;
    logic [4:0]  w_careg;
    logic [4:0]  w_cseq;
    logic [31:0] w_cwdata;
    logic        w_cwen;

    complete_arbiter #(.p_num_pipes(2), .p_num_phys_regs(36), .p_seq_num_bits(5)) dut_a (
        .clk(clk), .rst(rst),
        .pipe_preg(a_preg), .pipe_areg(a_areg), .pipe_seq_num(a_seq),
        .pipe_wdata(a_wdata), .pipe_wen(a_wen), .pipe_en(a_en), .pipe_rdy(a_rdy),
        .complete_val(a_val), .complete_preg(a_cpreg), .complete_areg(a_careg),
        .complete_seq_num(a_cseq), .complete_wdata(a_cwdata), .complete_wen(a_cwen)
    );

    complete_arbiter #(.p_num_pipes(3), .p_num_phys_regs(64), .p_seq_num_bits(5)) dut_w (
        .clk(clk), .rst(rst),
        .pipe_preg(w_preg), .pipe_areg(w_areg), .pipe_seq_num(w_seq),
        .pipe_wdata(w_wdata), .pipe_wen(w_wen), .pipe_en(w_en), .pipe_rdy(w_rdy),
        .complete_val(w_val), .complete_preg(w_cpreg), .complete_areg(w_careg),
        .complete_seq_num(w_cseq), .complete_wdata(w_cwdata), .complete_wen(w_cwen)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every valid broadcast must match the head of its scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && a_val === 1'b1) begin
            valid_seen++;
            if (qa.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected: valid preg %0d at edge %0d, expected no broadcast",
                         a_cpreg, edge_cnt);
            end else begin
                ea = qa.pop_front();
                check("a_payload", {a_cpreg, a_careg, a_cseq, a_cwdata, a_cwen},
                      {ea.preg, ea.areg, ea.seq, ea.wdata, ea.wen});
                check("a_edge", edge_cnt, ea.at);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && w_val === 1'b1) begin
            if (qw.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL w_unexpected: valid preg %0d at edge %0d, expected no broadcast",
                         w_cpreg, edge_cnt);
            end else begin
                ew = qw.pop_front();
                check("w_payload", {w_cpreg, w_careg, w_cseq, w_cwdata, w_cwen},
                      {ew.preg, ew.areg, ew.seq, ew.wdata, ew.wen});
                check("w_edge", edge_cnt, ew.at);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_exp(logic [5:0] preg, logic [4:0] areg, logic [4:0] seq,
                         logic [31:0] wdata, logic wen, int at);
        exp_t e;
        e.preg = preg; e.areg = areg; e.seq = seq; e.wdata = wdata; e.wen = wen; e.at = at;
        qa.push_back(e);
    endtask

    task automatic w_exp(logic [5:0] preg, logic [4:0] areg, logic [4:0] seq,
                         logic [31:0] wdata, logic wen, int at);
        exp_t e;
        e.preg = preg; e.areg = areg; e.seq = seq; e.wdata = wdata; e.wen = wen; e.at = at;
        qw.push_back(e);
    endtask

    task automatic a_drive(int p, logic [5:0] preg, logic [4:0] areg, logic [4:0] seq,
                           logic [31:0] wdata, logic wen);
        check($sformatf("a_rdy_before_en%0d", p), a_rdy[p], 1);
        a_en[p] = 1'b1; a_preg[p] = preg; a_areg[p] = areg;
        a_seq[p] = seq; a_wdata[p] = wdata; a_wen[p] = wen;
    endtask

    task automatic w_drive(int p, logic [5:0] preg, logic [4:0] areg, logic [4:0] seq,
                           logic [31:0] wdata, logic wen);
        check($sformatf("w_rdy_before_en%0d", p), w_rdy[p], 1);
        w_en[p] = 1'b1; w_preg[p] = preg; w_areg[p] = areg;
        w_seq[p] = seq; w_wdata[p] = wdata; w_wen[p] = wen;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 2; p++) a_en[p] = 1'b0;
        for (int p = 0; p < 3; p++) w_en[p] = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       base;
        int       mark;
        int       i0;
        int       i1;
        bit [7:0] s0;
        bit [7:0] s1;
        s0 = 8'h57;
        s1 = 8'hAB;
        for (int p = 0; p < 2; p++) begin
            a_preg[p] = '0; a_areg[p] = '0; a_seq[p] = '0;
            a_wdata[p] = '0; a_wen[p] = 1'b0; a_en[p] = 1'b0;
        end
        for (int p = 0; p < 3; p++) begin
            w_preg[p] = '0; w_areg[p] = '0; w_seq[p] = '0;
            w_wdata[p] = '0; w_wen[p] = 1'b0; w_en[p] = 1'b0;
        end
        rst = 1'b0;
        step(2);
        check("rst_val", a_val, 0);
        check("rst_payload", {a_cpreg, a_careg, a_cseq, a_cwdata, a_cwen}, 0);
        check("rst_rdy0", a_rdy[0], 1);
        check("rst_rdy1", a_rdy[1], 1);
        check("rst_w_val", w_val, 0);
        rst = 1'b1;

        // Single completion.
        base = edge_cnt;
        a_exp(6'd32, 5'd1, 5'd3, 32'hDEADBEEF, 1'b1, base + 2);
        a_drive(0, 6'd32, 5'd1, 5'd3, 32'hDEADBEEF, 1'b1);
        step();
        idle_all();
        step();
        check("t1_val_n2", a_val, 1);
        step();
        check("t1_val_n3", a_val, 0);
        step(2);

        // Simultaneous arrival.
        do_reset();
        base = edge_cnt;
        a_exp(6'd10, 5'd2, 5'd4, 32'h0000_1010, 1'b1, base + 2);
        a_exp(6'd20, 5'd3, 5'd5, 32'h0000_2020, 1'b0, base + 3);
        a_drive(0, 6'd10, 5'd2, 5'd4, 32'h0000_1010, 1'b1);
        a_drive(1, 6'd20, 5'd3, 5'd5, 32'h0000_2020, 1'b0);
        step();
        idle_all();
        step(4);

        // Round-robin fairness: enqueue whenever ready for 8 cycles.
        do_reset();
        base = edge_cnt;
        for (int k = 0; k < 5; k++) begin
            a_exp(6'(1 + k), 5'(k), 5'(k), 32'hA000_0000 + 32'(k), 1'b1, base + 2 + 2 * k);
            a_exp(6'(11 + k), 5'(16 + k), 5'(16 + k), 32'hB000_0000 + 32'(k), 1'(k),
                  base + 3 + 2 * k);
        end
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("t3_rdy0_c%0d", c), a_rdy[0], s0[c]);
            check($sformatf("t3_rdy1_c%0d", c), a_rdy[1], s1[c]);
            a_en[0] = 1'b0;
            a_en[1] = 1'b0;
            if (s0[c]) begin
                a_drive(0, 6'(1 + i0), 5'(i0), 5'(i0), 32'hA000_0000 + 32'(i0), 1'b1);
                i0++;
            end
            if (s1[c]) begin
                a_drive(1, 6'(11 + i1), 5'(16 + i1), 5'(16 + i1), 32'hB000_0000 + 32'(i1), 1'(i1));
                i1++;
            end
            step();
        end
        idle_all();
        step(6);

        // Full FIFO on pipe 1.
        do_reset();
        base = edge_cnt;
        a_exp(6'd30, 5'd7, 5'd1, 32'h3030_0000, 1'b1, base + 2);
        a_exp(6'd5,  5'd8, 5'd2, 32'h0505_0505, 1'b1, base + 3);
        a_exp(6'd31, 5'd9, 5'd3, 32'h3131_0000, 1'b0, base + 4);
        a_exp(6'd6,  5'd10, 5'd4, 32'h0606_0606, 1'b1, base + 5);
        a_drive(0, 6'd30, 5'd7, 5'd1, 32'h3030_0000, 1'b1);
        a_drive(1, 6'd5,  5'd8, 5'd2, 32'h0505_0505, 1'b1);
        step();
        a_drive(0, 6'd31, 5'd9, 5'd3, 32'h3131_0000, 1'b0);
        a_drive(1, 6'd6,  5'd10, 5'd4, 32'h0606_0606, 1'b1);
        step();
        idle_all();
        check("t4_rdy1_full", a_rdy[1], 0);
        check("t4_rdy0", a_rdy[0], 1);
        step();
        check("t4_rdy1_after_grant", a_rdy[1], 1);
        step(4);

        // Mid-operation reset with three entries buffered.
        do_reset();
        base = edge_cnt;
        a_exp(6'd7, 5'd1, 5'd1, 32'h0000_0007, 1'b1, base + 2);
        a_drive(0, 6'd7,  5'd1, 5'd1, 32'h0000_0007, 1'b1);
        a_drive(1, 6'd8,  5'd2, 5'd2, 32'h0000_0008, 1'b1);
        step();
        a_drive(0, 6'd9,  5'd3, 5'd3, 32'h0000_0009, 1'b1);
        a_drive(1, 6'd10, 5'd4, 5'd4, 32'h0000_000A, 1'b1);
        step();
        idle_all();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_val_async", a_val, 0);
        check("t5_payload_async", {a_cpreg, a_careg, a_cseq, a_cwdata, a_cwen}, 0);
        check("t5_rdy0", a_rdy[0], 1);
        check("t5_rdy1", a_rdy[1], 1);
        mark = valid_seen;
        step(2);
        rst = 1'b1;
        step(6);
        check("t5_no_stale", valid_seen - mark, 0);

        // Wide configuration: pointer wraps from pipe 2 back to pipe 0.
        do_reset();
        base = edge_cnt;
        w_exp(6'd1, 5'd1, 5'd1, 32'h1111_1111, 1'b1, base + 2);
        w_drive(1, 6'd1, 5'd1, 5'd1, 32'h1111_1111, 1'b1);
        step();
        idle_all();
        step();
        w_exp(6'd63, 5'd31, 5'd2, 32'h6363_6363, 1'b1, base + 4);
        w_drive(2, 6'd63, 5'd31, 5'd2, 32'h6363_6363, 1'b1);
        step();
        idle_all();
        step();
        w_exp(6'd40, 5'd4, 5'd4, 32'h4040_4040, 1'b0, base + 6);
        w_exp(6'd41, 5'd5, 5'd5, 32'h4141_4141, 1'b1, base + 7);
        w_exp(6'd42, 5'd6, 5'd6, 32'h4242_4242, 1'b1, base + 8);
        w_drive(1, 6'd41, 5'd5, 5'd5, 32'h4141_4141, 1'b1);
        w_drive(2, 6'd42, 5'd6, 5'd6, 32'h4242_4242, 1'b1);
        w_drive(0, 6'd40, 5'd4, 5'd4, 32'h4040_4040, 1'b0);
        step();
        idle_all();
        step(6);

        check("a_queue_drained", qa.size(), 0);
        check("w_queue_drained", qw.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
